// File: rtl/pyramid_sprite_mover_if.sv
// Jump command handshake between the Nios command registers and the motion engine.
//   e_jump_valid : command strobe (from software side)
//   e_jump       : 001 down-right, 010 down-left, 011 up-right, 100 up-left
//   cmd_ready    : high when a strobe will be accepted (from the mover)
interface pyramid_sprite_mover_if;
  logic       e_jump_valid;
  logic [2:0] e_jump;
  logic       cmd_ready;

  modport master (output e_jump_valid, output e_jump, input cmd_ready);
  modport slave  (input e_jump_valid, input e_jump, output cmd_ready);
endinterface

// File: rtl/pyramid_sprite_mover.sv
// Motion engine for one pyramid character. Owns the cube coordinate, animates
// the sprite centre in two phases per jump, and runs FALL/KO/RESPAWN when a
// jump leaves the pyramid.
// Ports:
//   clk, reset (async, active-low)
//   e_start / e_pause / e_resume : control pulses (start has highest priority)
//   cmd        : jump command handshake (slave side)
//   e_speed    : clocks per tick, 0 selects DEFAULT_SPEED
//   x_step, y_step, x_origin, y_origin : pyramid geometry in pixels
//   sprite_xy  : {x, y} current centre
//   row, col, cube_onehot : current cube
//   state      : 0 IDLE, 1 JUMP, 2 FALL, 3 KO, 4 RESPAWN
//   paused, done_move, ko_count : status back to software
module pyramid_sprite_mover #(
  parameter int N_ROWS        = 7,
  parameter int STEP          = 1,
  parameter int DEFAULT_SPEED = 100000,
  parameter int FALL_PIX      = 64,
  parameter int KO_TICKS      = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               e_start,
  input  logic                               e_pause,
  input  logic                               e_resume,
  pyramid_sprite_mover_if.slave              cmd,
  input  logic [31:0]                        e_speed,
  input  logic [10:0]                        x_step,
  input  logic [9:0]                         y_step,
  input  logic [10:0]                        x_origin,
  input  logic [9:0]                         y_origin,
  output logic [20:0]                        sprite_xy,
  output logic [$clog2(N_ROWS)-1:0]          row,
  output logic [$clog2(N_ROWS)-1:0]          col,
  output logic [N_ROWS*(N_ROWS+1)/2-1:0]     cube_onehot,
  output logic [2:0]                         state,
  output logic                               paused,
  output logic                               done_move,
  output logic [3:0]                         ko_count
);
  localparam int RW     = $clog2(N_ROWS);
  localparam int N_CUBE = N_ROWS * (N_ROWS + 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_JUMP = 3'd1, S_FALL = 3'd2, S_KO = 3'd3, S_RESPAWN = 3'd4
  } st_t;

  // Move p toward t by STEP, never past t. Direction comes from the command,
  // so wrap-around in the modulo pixel space is handled by the remaining distance.
  function automatic logic [10:0] clamp_step_x(input logic [10:0] p, input logic [10:0] t,
                                               input logic neg);
    logic [10:0] rem;
    rem = neg ? (p - t) : (t - p);
    if (rem <= 11'(STEP)) return t;
    return neg ? (p - 11'(STEP)) : (p + 11'(STEP));
  endfunction

  function automatic logic [9:0] clamp_step_y(input logic [9:0] p, input logic [9:0] t,
                                              input logic neg);
    logic [9:0] rem;
    rem = neg ? (p - t) : (t - p);
    if (rem <= 10'(STEP)) return t;
    return neg ? (p - 10'(STEP)) : (p + 10'(STEP));
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [N_CUBE-1:0] cube_bit(input logic [RW-1:0] r, input logic [RW-1:0] c);
    int idx;
    idx = (int'(r) * (int'(r) + 1)) / 2 + int'(c);
    return N_CUBE'(1) << idx;
  endfunction

  st_t           st;
  logic [31:0]   tick_cnt, aux_cnt;
  // Sprite position is kept as an offset from the origin so reset needs no data load.
  logic [10:0]   xo, txo;
  logic [9:0]    yo, tyo;
  logic [RW-1:0] trow, tcol;
  logic          cur_down, cur_yneg, bad;
  logic          pend_v;
  logic [2:0]    pend_cmd;

  logic [31:0]   period, fall_rem, fall_step;
  logic          paused_nxt, frz, tick, code_ok, acc, arrive, valid_land, nxt_go;
  logic [2:0]    nxt_cmd;
  logic          nxt_down, nxt_yneg;
  logic [RW-1:0] nxt_row, nxt_col;
  logic [10:0]   nxt_xo;
  logic [9:0]    nxt_yo;

  assign sprite_xy     = {x_origin + xo, y_origin + yo};
  assign cube_onehot   = cube_bit(row, col);
  assign state         = st;
  assign cmd.cmd_ready = !paused && !pend_v;

  // Control decode: pause freezes the same cycle it is requested.
  always_comb begin
    period     = (e_speed == 32'd0) ? 32'(DEFAULT_SPEED) : e_speed;
    paused_nxt = paused;
    if (e_pause && !e_resume)      paused_nxt = 1'b1;
    else if (e_resume && !e_pause) paused_nxt = 1'b0;
    frz        = paused_nxt;
    tick       = (st != S_IDLE) && !frz && (tick_cnt == period - 32'd1);
    code_ok    = (cmd.e_jump >= 3'b001) && (cmd.e_jump <= 3'b100);
    acc        = cmd.e_jump_valid && cmd.cmd_ready && code_ok && !frz;
    arrive     = (st == S_JUMP) && !frz && (xo == txo) && (yo == tyo);
    valid_land = arrive && !bad;
    nxt_go     = valid_land ? (pend_v || acc) : ((st == S_IDLE) && acc);
    fall_rem   = 32'(FALL_PIX) - aux_cnt;
    fall_step  = (fall_rem < 32'(STEP)) ? fall_rem : 32'(STEP);
  end

  // Next jump target, based on the cube the character is standing on (trow/tcol
  // equal row/col in IDLE and hold the landing cube on a valid arrival).
  always_comb begin
    nxt_cmd  = (valid_land && pend_v) ? pend_cmd : cmd.e_jump;
    nxt_down = (nxt_cmd == 3'b001) || (nxt_cmd == 3'b010);
    nxt_yneg = (nxt_cmd == 3'b010) || (nxt_cmd == 3'b100);
    nxt_row  = nxt_down ? (trow + RW'(1)) : (trow - RW'(1));
    nxt_col  = tcol;
    if (nxt_cmd == 3'b001)      nxt_col = tcol + RW'(1);
    else if (nxt_cmd == 3'b100) nxt_col = tcol - RW'(1);
    nxt_xo   = nxt_down ? (txo + x_step) : (txo - x_step);
    nxt_yo   = nxt_yneg ? (tyo - y_step) : (tyo + y_step);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_IDLE; tick_cnt <= '0; aux_cnt <= '0;
      xo <= '0; yo <= '0; txo <= '0; tyo <= '0;
      row <= '0; col <= '0; trow <= '0; tcol <= '0;
      cur_down <= 1'b0; cur_yneg <= 1'b0; bad <= 1'b0;
      pend_v <= 1'b0; pend_cmd <= '0;
      paused <= 1'b0; done_move <= 1'b0; ko_count <= '0;
    end else if (e_start) begin
      st <= S_IDLE; tick_cnt <= '0; aux_cnt <= '0;
      xo <= '0; yo <= '0; txo <= '0; tyo <= '0;
      row <= '0; col <= '0; trow <= '0; tcol <= '0;
      cur_down <= 1'b0; cur_yneg <= 1'b0; bad <= 1'b0;
      pend_v <= 1'b0; pend_cmd <= '0;
      paused <= 1'b0; done_move <= 1'b0; ko_count <= '0;
    end else begin
      paused    <= paused_nxt;
      done_move <= 1'b0;
      if (!frz) begin
        if (st == S_IDLE || tick) tick_cnt <= '0;
        else                      tick_cnt <= tick_cnt + 32'd1;

        case (st)
          S_IDLE: ;
          S_JUMP: begin
            if (arrive) begin
              if (bad) begin
                st      <= S_FALL;
                pend_v  <= 1'b0;
                aux_cnt <= '0;
              end else begin
                row       <= trow;
                col       <= tcol;
                done_move <= 1'b1;
                st        <= S_IDLE;
              end
            end else begin
              if (acc) begin
                pend_v   <= 1'b1;
                pend_cmd <= cmd.e_jump;
              end
              // Down jumps lead with y, up jumps lead with x.
              if (tick) begin
                if (cur_down) begin
                  if (yo != tyo) yo <= clamp_step_y(yo, tyo, cur_yneg);
                  else           xo <= clamp_step_x(xo, txo, 1'b0);
                end else begin
                  if (xo != txo) xo <= clamp_step_x(xo, txo, 1'b1);
                  else           yo <= clamp_step_y(yo, tyo, cur_yneg);
                end
              end
            end
          end
          S_FALL: begin
            if (tick) begin
              xo <= xo + fall_step[10:0];
              if (aux_cnt + fall_step >= 32'(FALL_PIX)) begin
                st       <= S_KO;
                aux_cnt  <= '0;
                ko_count <= sat_inc4(ko_count);
              end else begin
                aux_cnt <= aux_cnt + fall_step;
              end
            end
          end
          S_KO: begin
            if (tick) begin
              if (aux_cnt >= 32'(KO_TICKS) - 32'd1) begin
                st      <= S_RESPAWN;
                aux_cnt <= '0;
              end else begin
                aux_cnt <= aux_cnt + 32'd1;
              end
            end
          end
          S_RESPAWN: begin
            xo <= '0; yo <= '0; txo <= '0; tyo <= '0;
            row <= '0; col <= '0; trow <= '0; tcol <= '0;
            pend_v <= 1'b0;
            st     <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase

        // Starting a jump overrides the IDLE transition of a valid landing.
        if (nxt_go) begin
          st       <= S_JUMP;
          pend_v   <= 1'b0;
          trow     <= nxt_row;
          tcol     <= nxt_col;
          txo      <= nxt_xo;
          tyo      <= nxt_yo;
          cur_down <= nxt_down;
          cur_yneg <= nxt_yneg;
          bad      <= (nxt_down && trow == RW'(N_ROWS - 1)) || (!nxt_down && trow == '0) ||
                      (nxt_cmd == 3'b011 && tcol == trow) || (nxt_cmd == 3'b100 && tcol == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_pyramid_sprite_mover.sv
// Self-checking bench for pyramid_sprite_mover: a geometric model predicts each
// landing cube and pixel centre, queued at strobe time and compared on done_move.
module tb_pyramid_sprite_mover;
  localparam int N_ROWS = 7;
  localparam int N_CUBE = N_ROWS * (N_ROWS + 1) / 2;
  localparam int RW     = $clog2(N_ROWS);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              e_start = 1'b0, e_pause = 1'b0, e_resume = 1'b0;
  logic [31:0]       e_speed = 32'd3;
  logic [10:0]       x_step = 11'd4, x_origin = 11'd100;
  logic [9:0]        y_step = 10'd3, y_origin = 10'd180;
  logic [20:0]       sprite_xy;
  logic [RW-1:0]     row, col;
  logic [N_CUBE-1:0] cube_onehot;
  logic [2:0]        state;
  logic              paused, done_move;
  logic [3:0]        ko_count;

  pyramid_sprite_mover_if bus();

  pyramid_sprite_mover #(
    .N_ROWS(N_ROWS), .STEP(1), .DEFAULT_SPEED(100000), .FALL_PIX(64), .KO_TICKS(256)
  ) dut (
    .clk(clk), .reset(reset), .e_start(e_start), .e_pause(e_pause), .e_resume(e_resume),
    .cmd(bus), .e_speed(e_speed), .x_step(x_step), .y_step(y_step),
    .x_origin(x_origin), .y_origin(y_origin), .sprite_xy(sprite_xy), .row(row), .col(col),
    .cube_onehot(cube_onehot), .state(state), .paused(paused), .done_move(done_move),
    .ko_count(ko_count)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; int x; int y; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  int m_r = 0, m_c = 0;

  function automatic logic [N_CUBE-1:0] onehot_of(input int r, input int c);
    logic [N_CUBE-1:0] v;
    v = '0;
    v[r * (r + 1) / 2 + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [20:0] xy(input int x, input int y);
    return {11'(x), 10'(y)};
  endfunction

  // Scoreboard: every done_move pops the oldest predicted landing.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done_move) begin
      done_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL landing_unexpected: done_move at row=%0d col=%0d xy=%h, required no landing",
                 row, col, sprite_xy);
      end else begin
        e = exp_q.pop_front();
        if (row !== RW'(e.r) || col !== RW'(e.c) || sprite_xy !== xy(e.x, e.y) ||
            cube_onehot !== onehot_of(e.r, e.c)) begin
          n_fail++;
          $display("FAIL landing: row=%0d col=%0d x=%0d y=%0d onehot=%h, required row=%0d col=%0d x=%0d y=%0d onehot=%h",
                   row, col, sprite_xy[20:10], sprite_xy[9:0], cube_onehot,
                   e.r, e.c, e.x, e.y, onehot_of(e.r, e.c));
        end
      end
    end
  end

  task automatic model_clear();
    m_r = 0;
    m_c = 0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); e_start = 1'b1;
    @(negedge clk); e_start = 1'b0;
    model_clear();
  endtask

  // One-cycle strobe; if the bench expects acceptance, predict the landing.
  task automatic send_jump(input logic [2:0] code, input bit expect_accept);
    exp_t e;
    int nr, nc;
    bit down;
    @(negedge clk); bus.e_jump_valid = 1'b1; bus.e_jump = code;
    @(negedge clk); bus.e_jump_valid = 1'b0;
    if (expect_accept) begin
      down = (code == 3'b001) || (code == 3'b010);
      nr = down ? m_r + 1 : m_r - 1;
      nc = (code == 3'b001) ? m_c + 1 : (code == 3'b100) ? m_c - 1 : m_c;
      if (nr >= 0 && nr < N_ROWS && nc >= 0 && nc <= nr) begin
        e.r = nr; e.c = nc;
        e.x = 100 + nr * 4;
        e.y = 180 + (2 * nc - nr) * 3;
        exp_q.push_back(e);
        m_r = nr; m_c = nc;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s: %0d landings after %0d cycles, required %0d", name, done_cnt, k, target);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (state !== s && k < budget) begin @(negedge clk); #1; k++; end
    n_checks++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, state, k, s);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (sprite_xy !== xy(100, 180) || row !== '0 || col !== '0 || cube_onehot !== onehot_of(0, 0) ||
        state !== 3'd0 || bus.cmd_ready !== 1'b1 || ko_count !== 4'd0 || paused !== 1'b0 ||
        done_move !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: xy=%h row=%0d col=%0d onehot=%h state=%0d ready=%b ko=%0d paused=%b done=%b, required xy=%h 0 0 1 0 1 0 0 0",
               sprite_xy, row, col, cube_onehot, state, bus.cmd_ready, ko_count, paused, done_move, xy(100, 180));
    end
  endtask

  task automatic test_jump_down_right();
    int cyc, base;
    pulse_start();
    base = done_cnt;
    send_jump(3'b001, 1'b1);
    cyc = 0;
    while (done_move !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 22) begin
      n_fail++;
      $display("FAIL jump_latency: landing after %0d cycles, required 22", cyc);
    end
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL jump_idle: state=%0d, required 0", state);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_move !== 1'b0 || done_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL jump_pulse: done_move=%b landings=%0d, required 0 and %0d", done_move, done_cnt - base, 1);
    end
  endtask

  task automatic test_bad_jump();
    int base;
    pulse_start();
    base = done_cnt;
    send_jump(3'b100, 1'b1);
    wait_state(3'd2, 100, "bad_enter_fall");
    n_checks++;
    if (sprite_xy !== xy(96, 177) || row !== '0 || col !== '0) begin
      n_fail++;
      $display("FAIL bad_arrival: xy=%h row=%0d col=%0d, required xy=%h row=0 col=0", sprite_xy, row, col, xy(96, 177));
    end
    wait_state(3'd3, 400, "bad_enter_ko");
    n_checks++;
    if (sprite_xy !== xy(160, 177) || ko_count !== 4'd1) begin
      n_fail++;
      $display("FAIL fall_end: xy=%h ko=%0d, required xy=%h ko=1", sprite_xy, ko_count, xy(160, 177));
    end
    wait_state(3'd4, 1200, "bad_enter_respawn");
    @(negedge clk); #1;
    n_checks++;
    if (state !== 3'd0 || sprite_xy !== xy(100, 180) || row !== '0 || col !== '0 ||
        cube_onehot !== onehot_of(0, 0) || ko_count !== 4'd1 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL respawn: state=%0d xy=%h row=%0d col=%0d ko=%0d ready=%b, required 0 %h 0 0 1 1",
               state, sprite_xy, row, col, ko_count, bus.cmd_ready, xy(100, 180));
    end
    n_checks++;
    if (done_cnt !== base) begin
      n_fail++;
      $display("FAIL bad_no_done: landings=%0d, required 0", done_cnt - base);
    end
  endtask

  // Runs straight after test_bad_jump so ko_count starts at 1.
  task automatic test_start_mid_fall();
    send_jump(3'b100, 1'b1);
    wait_state(3'd2, 100, "start_enter_fall");
    repeat (10) @(negedge clk);
    e_start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 3'd0 || sprite_xy !== xy(100, 180) || row !== '0 || col !== '0 ||
        cube_onehot !== onehot_of(0, 0) || ko_count !== 4'd0 || paused !== 1'b0 ||
        bus.cmd_ready !== 1'b1 || done_move !== 1'b0) begin
      n_fail++;
      $display("FAIL start_mid_fall: state=%0d xy=%h row=%0d col=%0d ko=%0d ready=%b, required 0 %h 0 0 0 1",
               state, sprite_xy, row, col, ko_count, bus.cmd_ready, xy(100, 180));
    end
    @(negedge clk); e_start = 1'b0;
    model_clear();
  endtask

  task automatic test_back_to_back();
    int base;
    pulse_start();
    base = done_cnt;
    send_jump(3'b010, 1'b1);
    send_jump(3'b001, 1'b1);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready: cmd_ready=%b, required 0", bus.cmd_ready);
    end
    wait_done(base + 1, 100, "b2b_first");
    n_checks++;
    if (state !== 3'd1 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_chain: state=%0d ready=%b, required 1 1", state, bus.cmd_ready);
    end
    wait_done(base + 2, 100, "b2b_second");
    n_checks++;
    if (state !== 3'd0 || row !== RW'(2) || col !== RW'(1) || sprite_xy !== xy(108, 180)) begin
      n_fail++;
      $display("FAIL b2b_end: state=%0d row=%0d col=%0d xy=%h, required 0 2 1 %h",
               state, row, col, sprite_xy, xy(108, 180));
    end
  endtask

  task automatic test_pause();
    int base;
    logic [20:0] held;
    bit moved;
    pulse_start();
    base = done_cnt;
    send_jump(3'b001, 1'b1);
    repeat (9) @(negedge clk);
    e_pause = 1'b1;
    @(negedge clk); e_pause = 1'b0;
    held = sprite_xy;
    n_checks++;
    if (paused !== 1'b1 || bus.cmd_ready !== 1'b0 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_status: paused=%b ready=%b state=%0d, required 1 0 1", paused, bus.cmd_ready, state);
    end
    send_jump(3'b010, 1'b0);
    moved = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (sprite_xy !== held) moved = 1'b1;
    end
    n_checks++;
    if (moved !== 1'b0 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_freeze: moved=%b state=%0d, required 0 1", moved, state);
    end
    e_resume = 1'b1;
    @(negedge clk); e_resume = 1'b0;
    n_checks++;
    if (paused !== 1'b0) begin
      n_fail++;
      $display("FAIL resume: paused=%b, required 0", paused);
    end
    wait_done(base + 1, 100, "pause_landing");
    repeat (100) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== base + 1 || state !== 3'd0 || row !== RW'(1) || col !== RW'(1)) begin
      n_fail++;
      $display("FAIL pause_drop: landings=%0d state=%0d row=%0d col=%0d, required 1 0 1 1",
               done_cnt - base, state, row, col);
    end
  endtask

  task automatic test_reset_mid_jump();
    int base;
    pulse_start();
    base = done_cnt;
    send_jump(3'b001, 1'b1);
    send_jump(3'b010, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || sprite_xy !== xy(100, 180) || row !== '0 || col !== '0 ||
        cube_onehot !== onehot_of(0, 0) || bus.cmd_ready !== 1'b1 || done_move !== 1'b0 ||
        ko_count !== 4'd0 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_jump: state=%0d xy=%h row=%0d col=%0d ready=%b, required 0 %h 0 0 1",
               state, sprite_xy, row, col, bus.cmd_ready, xy(100, 180));
    end
    model_clear();
    @(negedge clk); reset = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== base || state !== 3'd0 || sprite_xy !== xy(100, 180)) begin
      n_fail++;
      $display("FAIL reset_discard: landings=%0d state=%0d xy=%h, required 0 0 %h",
               done_cnt - base, state, sprite_xy, xy(100, 180));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.e_jump_valid = 1'b0;
    bus.e_jump       = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_jump_down_right();
    test_bad_jump();
    test_start_mid_fall();
    test_back_to_back();
    test_pause();
    test_reset_mid_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pyramid_sprite_mover.md
Name: pyramid_sprite_mover

Overview:
Parametrised motion engine for one pyramid character (Q*bert, or an enemy instance). It owns the character's cube coordinate (row/col plus one-hot cube index) and computes the landing cube from a jump command. It animates the on-screen centre in two phases, detects off-pyramid jumps itself, and runs a fall/KO/respawn sequence. It sits between the Nios command registers and the pixel renderer: it drives `sprite_xy` to the draw layer and status back to software.

Parameters:
N_ROWS, 7, pyramid rows; N_CUBE = N_ROWS*(N_ROWS+1)/2.
STEP, 1, pixels moved per speed tick (1..15).
DEFAULT_SPEED, 100000, tick period in clocks when `e_speed` = 0.
FALL_PIX, 64, pixels travelled in +x during FALL.
KO_TICKS, 256, ticks spent in KO before respawn.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
e_start  in  1  restart pulse; highest priority
e_pause  in  1  pause request pulse
e_resume  in  1  resume request pulse
e_jump_valid  in  1  jump command strobe
e_jump  in  3  001 down-right, 010 down-left, 011 up-right, 100 up-left
cmd_ready  out  1  high when a jump strobe will be accepted
e_speed  in  32  clocks per tick; 0 selects DEFAULT_SPEED
x_step  in  11  x pixel distance between adjacent rows
y_step  in  10  y pixel half-distance between adjacent columns
x_origin  in  11  x of top-cube centre
y_origin  in  10  y of top-cube centre
sprite_xy  out  21  {x[10:0], y[9:0]} current centre
row  out  $clog2(N_ROWS)  current row
col  out  $clog2(N_ROWS)  current column (0..row)
cube_onehot  out  N_CUBE  bit row*(row+1)/2+col set
state  out  3  0 IDLE, 1 JUMP, 2 FALL, 3 KO, 4 RESPAWN
paused  out  1  game frozen
done_move  out  1  one-cycle pulse on landing on a valid cube
ko_count  out  4  saturating KO counter

Behaviour:
- Reset (asynchronous, active-low), and `e_start` (synchronous):
  - state IDLE, row = col = 0, cube_onehot = 1, sprite_xy = {x_origin, y_origin}.
  - ko_count = 0, paused = 0, command buffer empty, tick counter = 0, done_move = 0.
- Tick generation:
  - Counter runs only while state ≠ IDLE and !paused.
  - A tick fires when counter = period-1; counter then clears.
  - period = e_speed, or DEFAULT_SPEED when e_speed = 0; sampled each cycle.
- Command buffer:
  - One executing command plus one pending entry.
  - cmd_ready = !paused && pending empty.
  - A strobe with e_jump ∉ {001..100}, or with cmd_ready = 0, is dropped.
  - In IDLE, an accepted command enters JUMP on the next cycle.
  - In JUMP, an accepted command is stored as pending.
- JUMP target, given current (r,c):
  - dr: down = +1, up = -1.
  - dc: 001 = +1, 010 = 0, 011 = 0, 100 = -1.
  - Pixel deltas: dx = ±x_step (+ for down); dy = +y_step for 001/011, -y_step for 010/100.
  - Target pixel = start + (dx,dy). All arithmetic is modulo 11/10 bits.
  - bad = (down && r = N_ROWS-1) || (up && r = 0) || (011 && c = r) || (100 && c = 0).
- JUMP animation:
  - Down jumps move y first, then x; up jumps move x first, then y.
  - Each tick moves the active axis STEP pixels toward target, clamped to target (no overshoot).
  - Arrival is the cycle both axes equal target.
  - Valid arrival: row/col/cube_onehot update, done_move pulses, then pending executes next cycle, or IDLE if none.
  - Bad arrival: no done_move, row/col unchanged, pending flushed, state FALL.
- Cube centre invariant: x = x_origin + r*x_step, y = y_origin + (2c - r)*y_step.
- FALL: x += STEP per tick for FALL_PIX pixels total, then KO; ko_count saturates at 15.
- KO: KO_TICKS ticks, then RESPAWN.
- RESPAWN: one cycle; row = col = 0, sprite at origin, buffer empty, then IDLE.
- Pause:
  - `e_pause` sets paused; counter, position and state freeze.
  - `e_resume` clears paused. Both asserted together: no change.
  - Pause in IDLE is allowed; strobes are dropped while paused.
- Priority: reset > e_start > pause/resume > command > tick.
- Simultaneous arrival and strobe in the same cycle: the strobe is accepted as pending if the buffer is free.

Test Plan:
Use N_ROWS=7, STEP=1, e_speed=3, x_step=4, y_step=3, origin (100,180) unless stated.
- Reset release: sprite_xy = {100,180}, row=0, col=0, cube_onehot=1, state=0, cmd_ready=1, ko_count=0.
- Jump 001 from top: 3 y-ticks then 4 x-ticks (21 clocks).
  - Required: done_move pulses once, sprite=(104,183), row=1, col=1, cube_onehot=0b100, state=0.
- Jump 100 from top (bad): arrives at (96,177), no done_move.
  - Then FALL to x=160, KO for 256 ticks, ko_count=1, RESPAWN, sprite=(100,180), state=0.
- Back-to-back 010 then 001 strobes 2 cycles apart.
  - Required: cmd_ready low after the second strobe; second jump starts the cycle after landing.
  - End state: row=2, col=1, sprite=(108,180), two done_move pulses.
- e_pause after 10 clocks of a jump, hold 50 clocks, then e_resume.
  - Required: sprite constant while paused, final landing identical to the unpaused run.
  - Required: a strobe issued during the pause is dropped.
- Reset asserted mid-JUMP, and separately e_start mid-FALL: all outputs immediately at reset values, pending command discarded.
